nibble_collector: RTL
=====================

NIBBLE_COLLECTOR -- requirements
Module: nibble_collector

Interface
REQ-001 SHALL provide parameter NIBBLES, default 4, number of 4-bit nibbles per assembled word (legal range 2..8).
REQ-002 SHALL provide parameter TIMEOUT_CYCLES, default 15, idle cycles before a partial word is discarded (legal range 1..255).
REQ-003 SHALL have port i_clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_reset, input, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have port i_sel, input, 1 bit, nibble strobe; i_a is valid in any cycle where i_sel=1.
REQ-006 SHALL have port i_a, input, 4 bits, nibble data.
REQ-007 SHALL have port o_word, output, 4*NIBBLES bits, assembled word.
REQ-008 SHALL have port o_valid, output, 1 bit, o_word holds a complete word.
REQ-009 SHALL have port i_ready, input, 1 bit, consumer accepts o_word when o_valid=1 at the same edge.
REQ-010 SHALL have port o_busy, output, 1 bit, a partial word is in progress.
REQ-011 SHALL have port o_overrun, output, 1 bit, one-cycle pulse when a nibble is dropped.
REQ-012 SHALL have port o_timeout, output, 1 bit, one-cycle pulse when a partial word is discarded.

Function
REQ-013 SHALL implement states IDLE, COLLECT, HOLD; every output and next-state value fully assigned on all paths (no inferred latches).
REQ-014 SHALL pack nibbles LSB-first: the first captured nibble goes to o_word[3:0], the k-th to o_word[4k+3:4k].
REQ-015 IDLE: i_sel=1 SHALL capture nibble 0, set count=1, enter COLLECT; i_sel=0 stays in IDLE.
REQ-016 COLLECT: each i_sel=1 SHALL capture at position count and increment count; o_busy=1 throughout COLLECT.
REQ-017 On capture of nibble NIBBLES-1, the FSM SHALL enter HOLD with o_valid=1 from the next cycle (latency 1 cycle after the final strobe edge).
REQ-018 HOLD: o_word and o_valid SHALL remain stable until an edge with i_ready=1; the FSM then returns to IDLE.
REQ-019 HOLD with i_sel=1 and i_ready=1 at the same edge SHALL complete the handshake and capture the nibble as nibble 0 of the next word (count=1, COLLECT).
REQ-020 HOLD with i_sel=1 and i_ready=0 SHALL drop the nibble and pulse o_overrun for exactly one cycle.
REQ-021 o_word SHALL read all zeros whenever o_valid=0 (default-zero output mux).
REQ-022 The count SHALL wrap to 0 after the final nibble and SHALL never index beyond NIBBLES-1.

Reset
REQ-023 Asserting i_reset SHALL immediately force IDLE, count=0, internal buffer=0, o_word=0, o_valid=0, o_busy=0, o_overrun=0, o_timeout=0.
REQ-024 Reset during COLLECT or HOLD SHALL discard the partial or held word with no o_overrun or o_timeout pulse.
REQ-025 After deassertion, the first i_sel=1 SHALL be captured as nibble 0.

Configuration
REQ-026 Macro NIBBLE_COLLECTOR_TIMEOUT_EN SHALL gate the idle-timeout feature.
REQ-027 With the macro defined: in COLLECT, consecutive i_sel=0 cycles SHALL be counted; reaching TIMEOUT_CYCLES SHALL discard the partial word, return to IDLE, and pulse o_timeout for one cycle; any i_sel=1 SHALL clear the counter.
REQ-028 Without the macro: no timer logic SHALL exist, o_timeout SHALL be tied to 0, and COLLECT SHALL wait indefinitely.

Structure
REQ-029 Package collector_pkg SHALL hold the state encoding constants (IDLE=2'd0, COLLECT=2'd1, HOLD=2'd2) and the default NIBBLES/TIMEOUT_CYCLES values.
REQ-030 The idle timer SHALL be a sub-module collector_timer, instantiated only under NIBBLE_COLLECTOR_TIMEOUT_EN.

Verification
REQ-031 NIBBLES=4, strobes 0x1,0x2,0x3,0x4 on consecutive cycles, i_ready=0 -> o_valid=1 one cycle after the 4th strobe, o_word=16'h4321, held stable.
REQ-032 In HOLD, i_sel=1 with i_a=0x9 and i_ready=0 -> o_overrun pulses 1 cycle, o_word still 16'h4321; then i_ready=1 -> o_valid=0 and o_word=16'h0000 next cycle.
REQ-033 In HOLD, i_ready=1 and i_sel=1 with i_a=0xA at the same edge -> o_valid=0, o_busy=1, next completed word has [3:0]=0xA.
REQ-034 Two nibbles captured, then i_reset asserted mid-cycle -> all outputs 0 immediately; after release, strobes 0x5,0x6,0x7,0x8 -> o_word=16'h8765.
REQ-035 Macro defined, TIMEOUT_CYCLES=15, one nibble then 15 idle cycles -> o_timeout pulses once, o_busy=0; macro undefined, same stimulus -> o_busy stays 1, o_timeout=0.

Source files
------------

// File: rtl/collector_pkg.sv
// rtl/collector_pkg.sv - shared state encoding and default parameters for nibble_collector
//
// Purpose : FSM state type and the default NIBBLES / TIMEOUT_CYCLES values
//           used by nibble_collector and collector_timer.
// Ports   : none (package)
package collector_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  localparam int NIBBLES_DEFAULT        = 4;
  localparam int TIMEOUT_CYCLES_DEFAULT = 15;

endpackage

// File: rtl/collector_timer.sv
// rtl/collector_timer.sv - idle-cycle timer that flags an abandoned partial word
//
// Purpose : counts consecutive cycles with i_run=1; o_expire is high in the
//           cycle that completes the TIMEOUT_CYCLES-th consecutive idle cycle.
// Ports   : i_clk    - clock, rising edge
//           i_reset  - asynchronous active-high reset
//           i_run    - 1 while a partial word is waiting and no strobe is seen
//           o_expire - combinational, the current cycle is the last allowed one
module collector_timer
  import collector_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_run,
  output logic o_expire
);

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    o_expire = i_run && (cnt_q == LAST_CNT);
    cnt_d    = cnt_q;
    // Any strobe (or leaving COLLECT) drops i_run and restarts the count.
    if (!i_run || o_expire) begin
      cnt_d = 8'd0;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

endmodule

// File: rtl/nibble_collector.sv
// rtl/nibble_collector.sv - assembles NIBBLES 4-bit strobes into one word with a hold handshake
//
// Purpose : packs nibbles LSB-first into a word, holds it until i_ready, flags
//           dropped nibbles, optionally discards stalled partial words.
// Macro   : NIBBLE_COLLECTOR_TIMEOUT_EN enables the idle timeout (collector_timer).
// Ports   : i_clk     - clock, rising edge
//           i_reset   - asynchronous active-high reset
//           i_sel     - nibble strobe, i_a valid when 1
//           i_a       - nibble data
//           o_word    - assembled word, zero unless o_valid
//           o_valid   - o_word holds a complete word
//           i_ready   - consumer takes o_word at an edge with o_valid=1
//           o_busy    - partial word in progress
//           o_overrun - one-cycle pulse, nibble dropped while holding
//           o_timeout - one-cycle pulse, partial word discarded
module nibble_collector
  import collector_pkg::*;
#(
  parameter int NIBBLES        = NIBBLES_DEFAULT,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_sel,
  input  logic [3:0]             i_a,
  output logic [4*NIBBLES-1:0]   o_word,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic                   o_busy,
  output logic                   o_overrun,
  output logic                   o_timeout
);

  localparam int              CW   = $clog2(NIBBLES);
  localparam logic [CW-1:0]   LAST = CW'(NIBBLES - 1);
  localparam logic [CW-1:0]   ONE  = CW'(1);

  if (NIBBLES < 2 || NIBBLES > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_cfg
    $error("nibble_collector: NIBBLES must be 2..8 and TIMEOUT_CYCLES 1..255");
  end

  state_t               state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic [4*NIBBLES-1:0] buf_q,   buf_d;
  logic                 overrun_q, overrun_d;
  logic                 timeout_expire;

`ifdef NIBBLE_COLLECTOR_TIMEOUT_EN
  logic timeout_q;

  collector_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_run    ((state_q == COLLECT) && !i_sel),
    .o_expire (timeout_expire)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_expire;
    end
  end

  assign o_timeout = timeout_q;
`else
  assign timeout_expire = 1'b0;
  assign o_timeout      = 1'b0;
`endif

  // State register and datapath flops.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      buf_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      buf_q     <= buf_d;
      overrun_q <= overrun_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    buf_d     = buf_q;
    overrun_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_sel) begin
          buf_d      = '0;
          buf_d[3:0] = i_a;
          count_d    = ONE;
          state_d    = COLLECT;
        end
      end
      COLLECT: begin
        if (i_sel) begin
          buf_d[4*int'(count_q) +: 4] = i_a;
          if (count_q == LAST) begin
            count_d = '0;
            state_d = HOLD;
          end else begin
            count_d = count_q + ONE;
          end
        end else if (timeout_expire) begin
          buf_d   = '0;
          count_d = '0;
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (i_ready) begin
          // The handshake edge may also start the next word.
          buf_d = '0;
          if (i_sel) begin
            buf_d[3:0] = i_a;
            count_d    = ONE;
            state_d    = COLLECT;
          end else begin
            count_d = '0;
            state_d = IDLE;
          end
        end else if (i_sel) begin
          overrun_d = 1'b1;
        end
      end
      default: begin
        buf_d   = '0;
        count_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Outputs.
  always_comb begin
    o_valid   = (state_q == HOLD);
    o_busy    = (state_q == COLLECT);
    o_word    = o_valid ? buf_q : '0;
    o_overrun = overrun_q;
  end

endmodule
